// File: rtl/ptw_dcache_arbiter_if.sv
// ptw_dcache_arbiter_if: one walker <-> arbiter channel.
//   master : walker side (drives req_valid/req_paddr, receives resp_*)
//   slave  : arbiter side (receives the request, drives resp_*)
//   req_valid  level request, held until resp_done; dropping early aborts
//   req_paddr  PTE physical address (56b)
//   resp_done  1-cycle completion pulse
//   resp_error qualifies resp_done: timeout, data invalid
//   resp_data  PTE data (64b), valid only with resp_done
`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 2
`endif
`ifndef DATA_TYPE_D
`define DATA_TYPE_D 1
`endif

interface ptw_dcache_arbiter_if;
  logic        req_valid;
  logic [55:0] req_paddr;
  logic        resp_done;
  logic        resp_error;
  logic [63:0] resp_data;

  modport master (output req_valid, output req_paddr,
                  input resp_done, input resp_error, input resp_data);
  modport slave  (input req_valid, input req_paddr,
                  output resp_done, output resp_error, output resp_data);
endinterface

// File: rtl/ptw_dcache_arbiter.sv
// ptw_dcache_arbiter: shares the DCache PTW read port between the
// instruction-side (iptw) and data-side (dptw) page-table walkers.
//   clk, rst                  clock, async active-high reset
//   iptw, dptw                walker channels (ptw_dcache_arbiter_if.slave)
//   DCache_RdReq_PTW_*        registered request to DCache (level valid)
//   DCache_RdResp_PTW_Data    PTE returned by DCache
//   DCache_RdResp_PTW_Done    1-cycle DCache completion
// Round-robin grant, one walk in flight. Completions for aborted walks are
// swallowed; a watchdog forces an error completion if DCache goes silent,
// then DRAIN absorbs a possible late done before new grants.
`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 2
`endif
`ifndef DATA_TYPE_D
`define DATA_TYPE_D 1
`endif

module ptw_dcache_arbiter #(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  ptw_dcache_arbiter_if.slave        iptw,
  ptw_dcache_arbiter_if.slave        dptw,
  output logic                       DCache_RdReq_PTW_Valid,
  output logic [55:0]                DCache_RdReq_PTW_Paddr,
  output logic [`DATA_TYPE__LEN-1:0] DCache_RdReq_PTW_DataType,
  input  logic [63:0]                DCache_RdResp_PTW_Data,
  input  logic                       DCache_RdResp_PTW_Done
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;

  // owner / last_grant encoding: 0 = iptw, 1 = dptw
  state_t              state;
  logic                owner;
  logic                last_grant;
  logic                aborted;
  logic [TO_CNT_W-1:0] cnt;

  logic owner_vld, to_hit, busy, fwd_ok, dc_fin, to_fin, fin, gnt, any_req;

  assign DCache_RdReq_PTW_DataType = `DATA_TYPE__LEN'(`DATA_TYPE_D);

  assign owner_vld = owner ? dptw.req_valid : iptw.req_valid;
  assign to_hit    = (cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state == S_BUSY);
  // owner_vld also gates here so an abort in the completion cycle itself
  // is not forwarded to a walker that has already walked away
  assign fwd_ok    = busy && !aborted && owner_vld;
  assign dc_fin    = busy && DCache_RdResp_PTW_Done;
  assign to_fin    = busy && !DCache_RdResp_PTW_Done && to_hit;
  assign fin       = (dc_fin || to_fin) && fwd_ok;

  assign iptw.resp_done  = fin && !owner;
  assign iptw.resp_error = fin && !owner && to_fin;
  assign iptw.resp_data  = (fin && !owner && dc_fin) ? DCache_RdResp_PTW_Data : 64'd0;
  assign dptw.resp_done  = fin && owner;
  assign dptw.resp_error = fin && owner && to_fin;
  assign dptw.resp_data  = (fin && owner && dc_fin) ? DCache_RdResp_PTW_Data : 64'd0;

  // tie goes to whoever was not granted last
  assign any_req = iptw.req_valid || dptw.req_valid;
  assign gnt     = (iptw.req_valid && dptw.req_valid) ? !last_grant : dptw.req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= S_IDLE;
      owner                  <= 1'b0;
      last_grant             <= 1'b1;
      aborted                <= 1'b0;
      cnt                    <= '0;
      DCache_RdReq_PTW_Valid <= 1'b0;
      DCache_RdReq_PTW_Paddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // a done arriving here is stale and simply ignored
          if (any_req) begin
            owner                  <= gnt;
            last_grant             <= gnt;
            DCache_RdReq_PTW_Paddr <= gnt ? dptw.req_paddr : iptw.req_paddr;
            aborted                <= 1'b0;
            cnt                    <= '0;
            DCache_RdReq_PTW_Valid <= 1'b1;
            state                  <= S_BUSY;
          end
        end
        S_BUSY: begin
          // request stays up after an abort; only the response is dropped
          if (!owner_vld) aborted <= 1'b1;
          cnt <= cnt + 1'b1;
          if (DCache_RdResp_PTW_Done) begin
            DCache_RdReq_PTW_Valid <= 1'b0;
            cnt                    <= '0;
            state                  <= S_IDLE;
          end else if (to_hit) begin
            DCache_RdReq_PTW_Valid <= 1'b0;
            cnt                    <= '0;
            state                  <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt <= cnt + 1'b1;
          if (DCache_RdResp_PTW_Done || to_hit) begin
            cnt   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ptw_dcache_arbiter.sv
`ifndef DATA_TYPE__LEN
`define DATA_TYPE__LEN 2
`endif
`ifndef DATA_TYPE_D
`define DATA_TYPE_D 1
`endif

module tb_ptw_dcache_arbiter;
  localparam int T     = 8;
  localparam int NTX   = 160;
  localparam int RST_T = 80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ptw_dcache_arbiter_if iptw ();
  ptw_dcache_arbiter_if dptw ();

  logic                       dc_valid;
  logic [55:0]                dc_paddr;
  logic [`DATA_TYPE__LEN-1:0] dc_type;
  logic [63:0]                dc_data;
  logic                       dc_done;

  ptw_dcache_arbiter #(.TIMEOUT_CYCLES(T), .TO_CNT_W(16)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .iptw                      (iptw),
    .dptw                      (dptw),
    .DCache_RdReq_PTW_Valid    (dc_valid),
    .DCache_RdReq_PTW_Paddr    (dc_paddr),
    .DCache_RdReq_PTW_DataType (dc_type),
    .DCache_RdResp_PTW_Data    (dc_data),
    .DCache_RdResp_PTW_Done    (dc_done)
  );

  typedef struct {
    logic        w;
    logic        err;
    logic [63:0] data;
  } resp_t;

  resp_t       rq[$];
  logic [55:0] aq[$];
  int          nchk = 0;
  int          nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic        prev_valid = 1'b0;
  logic [55:0] cur_addr = '0;

  task automatic check_resp(input logic w, input logic err, input logic [63:0] data);
    resp_t e;
    if (rq.size() == 0) begin
      nchk++; nfail++;
      $display("FAIL unexpected_resp: walker %0d err %0d with nothing expected", w, err);
    end else begin
      e = rq.pop_front();
      chk("resp_walker", 64'(w), 64'(e.w));
      chk("resp_error", 64'(err), 64'(e.err));
      if (!e.err) chk("resp_data", data, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (dc_valid && !prev_valid) begin
      if (aq.size() == 0) begin
        nchk++; nfail++;
        $display("FAIL unexpected_dc_req: paddr %0h", dc_paddr);
      end else begin
        cur_addr = aq.pop_front();
        chk("dc_paddr", 64'(dc_paddr), 64'(cur_addr));
      end
    end else if (dc_valid) begin
      chk("dc_paddr_stable", 64'(dc_paddr), 64'(cur_addr));
    end
    prev_valid = dc_valid;
    if (iptw.resp_done) check_resp(1'b0, iptw.resp_error, iptw.resp_data);
    if (dptw.resp_done) check_resp(1'b1, dptw.resp_error, dptw.resp_data);
    if (!iptw.resp_done && !dptw.resp_done && rq.size() != 0) begin
      nchk++; nfail++;
      $display("FAIL missing_resp: expected walker %0d response not seen", rq[0].w);
      rq.delete();
    end
  end

  // ---------------- stimulus + reference model ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic obs(input string nm, input logic exp);
    @(negedge clk);
    chk(nm, 64'(dc_valid), 64'(exp));
  endtask

  logic        i_pend, d_pend, m_last, g, timeout, aborted, rst_case;
  logic [55:0] i_addr, d_addr;
  int          k, lim, abort_at, late;

  initial begin
    rst = 1'b1;
    iptw.req_valid = 1'b0; iptw.req_paddr = '0;
    dptw.req_valid = 1'b0; dptw.req_paddr = '0;
    dc_data = '0; dc_done = 1'b0;
    i_pend = 1'b0; d_pend = 1'b0; i_addr = '0; d_addr = '0;
    m_last = 1'b1;   // first tie goes to iptw
    tick; tick;
    @(negedge clk);
    chk("rst_valid", 64'(dc_valid), 64'd0);
    chk("rst_paddr", 64'(dc_paddr), 64'd0);
    chk("rst_datatype", 64'(dc_type), 64'(`DATA_TYPE__LEN'(`DATA_TYPE_D)));
    chk("rst_iptw_done", 64'(iptw.resp_done), 64'd0);
    chk("rst_dptw_done", 64'(dptw.resp_done), 64'd0);
    tick;
    rst = 1'b0;

    for (int t = 0; t < NTX; t++) begin
      // IDLE cycle: raise new requests, maybe a stray done
      if (!i_pend && (t == 0 || $urandom_range(0, 1) == 1)) begin
        i_pend = 1'b1; i_addr = 56'({$urandom(), $urandom()});
      end
      if (!d_pend && (t == 0 || $urandom_range(0, 1) == 1)) begin
        d_pend = 1'b1; d_addr = 56'({$urandom(), $urandom()});
      end
      if (!i_pend && !d_pend) begin
        i_pend = 1'b1; i_addr = 56'({$urandom(), $urandom()});
      end
      iptw.req_valid = i_pend; iptw.req_paddr = i_addr;
      dptw.req_valid = d_pend; dptw.req_paddr = d_addr;
      dc_done = ($urandom_range(0, 5) == 0);
      dc_data = 64'({$urandom(), $urandom()});
      g = (i_pend && d_pend) ? !m_last : d_pend;
      m_last = g;
      aq.push_back(g ? d_addr : i_addr);
      obs("idle_valid", 1'b0);
      tick;
      dc_done = 1'b0;

      rst_case = (t == RST_T);
      timeout  = !rst_case && ($urandom_range(0, 4) == 0);
      k        = $urandom_range(1, T);
      lim      = rst_case ? 2 : (timeout ? T : k);
      abort_at = (!rst_case && lim > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, lim - 1) : 0;
      aborted  = 1'b0;

      for (int c = 1; c <= lim; c++) begin
        if (c == abort_at) begin
          aborted = 1'b1;
          if (g) begin d_pend = 1'b0; dptw.req_valid = 1'b0; end
          else   begin i_pend = 1'b0; iptw.req_valid = 1'b0; end
        end
        dc_data = 64'({$urandom(), $urandom()});
        if (c == lim && !rst_case) begin
          if (!timeout) dc_done = 1'b1;
          if (!aborted) rq.push_back('{w: g, err: timeout, data: dc_data});
        end
        obs("busy_valid", 1'b1);
        tick;
        dc_done = 1'b0;
      end

      if (rst_case) begin
        rst = 1'b1;
        i_pend = 1'b0; d_pend = 1'b0;
        iptw.req_valid = 1'b0; dptw.req_valid = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 64'(dc_valid), 64'd0);
        chk("midrst_paddr", 64'(dc_paddr), 64'd0);
        tick;
        rst = 1'b0;
        obs("postrst_valid", 1'b0);
        tick;
        dc_done = 1'b1;           // stale done after reset: must be ignored
        obs("stale_done_valid", 1'b0);
        tick;
        dc_done = 1'b0;
        m_last = 1'b1;
        continue;
      end

      // owner drops its request the cycle after its completion
      if (!aborted) begin
        if (g) begin d_pend = 1'b0; dptw.req_valid = 1'b0; end
        else   begin i_pend = 1'b0; iptw.req_valid = 1'b0; end
      end

      if (timeout) begin
        late = ($urandom_range(0, 1) == 1) ? $urandom_range(1, T) : 0;
        for (int c = 1; c <= T; c++) begin
          if (c == late) dc_done = 1'b1;
          obs("drain_valid", 1'b0);
          tick;
          dc_done = 1'b0;
          if (c == late) break;
        end
      end
    end

    iptw.req_valid = 1'b0; dptw.req_valid = 1'b0;
    tick; tick; tick;
    chk("dc_queue_empty", 64'(aq.size()), 64'd0);
    chk("resp_queue_empty", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
